// File: rtl/fb_ring_ctrl.sv
`default_nettype none
// ============================================================================
// fb_ring_ctrl : NUM_FB-deep frame-buffer ring controller (init handshake,
//   burst gating, newest-frame selection). Macro FB_STATS_EN adds counters.
// Rev 1.0
// ============================================================================
module fb_ring_ctrl #(
  parameter int NUM_FB        = 3,
  parameter int WR_BURST_SIZE = 8,
  parameter int RD_BURST_SIZE = 16,
  parameter int IDXW          = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  output logic              init_start,
  input  logic              cam_empty,
  output logic              cam_rdreq,
  input  logic [NUM_FB-1:0] wr_ready,
  input  logic [NUM_FB-1:0] wr_full,
  output logic [NUM_FB-1:0] wr_en_n,
  input  logic              out_full,
  input  logic [NUM_FB-1:0] rd_done,
  input  logic [NUM_FB-1:0] rd_valid,
  output logic [NUM_FB-1:0] rd_en_n,
  output logic              out_wrreq,
  output logic [IDXW-1:0]   wr_sel,
  output logic [IDXW-1:0]   rd_sel,
  output logic [7:0]        frames_dropped,
  output logic [7:0]        frames_repeated
);

  localparam int WCW = (WR_BURST_SIZE > 1) ? $clog2(WR_BURST_SIZE) : 1;
  localparam int RCW = (RD_BURST_SIZE > 1) ? $clog2(RD_BURST_SIZE) : 1;
  localparam logic [WCW-1:0]  WR_LAST = WCW'(WR_BURST_SIZE - 1);
  localparam logic [RCW-1:0]  RD_LAST = RCW'(RD_BURST_SIZE - 1);
  localparam logic [IDXW-1:0] LAST    = IDXW'(NUM_FB - 1);

  typedef enum logic [1:0] {
    S_INIT      = 2'd0,
    S_INIT_WAIT = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t         state;
  logic [IDXW-1:0] newest;
  logic            newest_vld;
  logic            rd_seen;
  logic [WCW-1:0]  wr_cnt;
  logic            wr_gap;
  logic [RCW-1:0]  rd_cnt;
  logic            rd_gap;

  logic              run;
  logic [NUM_FB-1:0] wr_oh, rd_oh;
  logic              wr_beat, rd_beat, wr_evt, rd_evt;
  logic              rd_take, pick_ok, wr_yield;
  logic [IDXW-1:0]   rd_next, wr_next, cand1, cand2, wr_pick;

  function automatic logic [IDXW-1:0] next_slot(input logic [IDXW-1:0] s);
    return (s >= LAST) ? '0 : s + 1'b1;
  endfunction

  assign run     = (state == S_RUN);
  assign wr_oh   = NUM_FB'(1) << wr_sel;
  assign rd_oh   = NUM_FB'(1) << rd_sel;
  assign wr_beat = run && !wr_gap && !cam_empty && (|(wr_ready & wr_oh));
  assign rd_beat = run && !rd_gap && !out_full && (newest_vld || rd_seen);
  assign wr_evt  = run && (|(wr_full & wr_oh));
  assign rd_evt  = run && (|(rd_done & rd_oh));

  assign cam_rdreq = wr_beat;
  assign wr_en_n   = wr_beat ? ~wr_oh : '1;
  assign rd_en_n   = rd_beat ? ~rd_oh : '1;
  assign out_wrreq = run && (|rd_valid) && !out_full;

  // Writer avoids both the old and the new read slot; if the reader jumps onto
  // the slot the writer keeps, the writer moves into the slot the reader left.
  always_comb begin
    rd_take = rd_evt && newest_vld && (newest != rd_sel);
    rd_next = rd_take ? newest : rd_sel;
    cand1   = next_slot(wr_sel);
    cand2   = next_slot(cand1);
    wr_pick = cand1;
    pick_ok = 1'b1;
    if (cand1 == rd_sel || cand1 == rd_next) begin
      wr_pick = cand2;
      pick_ok = (NUM_FB >= 3) && (cand2 != rd_sel) && (cand2 != rd_next);
    end
    wr_next  = (wr_evt && pick_ok) ? wr_pick : wr_sel;
    wr_yield = rd_take && (wr_next == rd_next);
    if (wr_yield) wr_next = rd_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      init_start <= 1'b0;
      wr_sel     <= '0;
      rd_sel     <= LAST;
      newest     <= '0;
      newest_vld <= 1'b0;
      rd_seen    <= 1'b0;
      wr_cnt     <= '0;
      wr_gap     <= 1'b0;
      rd_cnt     <= '0;
      rd_gap     <= 1'b0;
    end else begin
      init_start <= 1'b0;
      case (state)
        S_INIT: begin
          state      <= S_INIT_WAIT;
          init_start <= 1'b1;
        end
        S_INIT_WAIT: if (init_done) state <= S_RUN;
        S_RUN:       state <= S_RUN;
        default:     state <= S_INIT;
      endcase

      wr_gap <= 1'b0;
      if (wr_beat) begin
        if (wr_cnt == WR_LAST) begin
          wr_cnt <= '0;
          wr_gap <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (wr_evt || wr_yield) wr_cnt <= '0;

      rd_gap <= 1'b0;
      if (rd_beat) begin
        if (rd_cnt == RD_LAST) begin
          rd_cnt <= '0;
          rd_gap <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
      if (rd_evt) begin
        rd_cnt  <= '0;
        rd_seen <= rd_seen | newest_vld;
      end

      // A newly completed frame wins over the reader consuming the old one.
      if (rd_take) newest_vld <= 1'b0;
      if (wr_evt) begin
        newest     <= wr_sel;
        newest_vld <= 1'b1;
      end
      wr_sel <= wr_next;
      rd_sel <= rd_next;
    end
  end

`ifdef FB_STATS_EN
  logic [7:0] drop_cnt, rep_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (wr_evt && !pick_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (rd_evt && !rd_take && rep_cnt != 8'hFF)  rep_cnt  <= rep_cnt + 8'd1;
    end
  end

  assign frames_dropped  = drop_cnt;
  assign frames_repeated = rep_cnt;
`else
  assign frames_dropped  = '0;
  assign frames_repeated = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_ring_ctrl.sv
`default_nettype none
// tb_fb_ring_ctrl: scoreboard bench; main instance NUM_FB=3, side instance NUM_FB=2.
module tb_fb_ring_ctrl;

`ifdef FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       init_start, cam_empty, cam_rdreq, out_full, out_wrreq;
  logic [2:0] wr_ready, wr_full, wr_en_n, rd_done, rd_valid, rd_en_n;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] frames_dropped, frames_repeated;

  logic       init_start_b, cam_rdreq_b, out_wrreq_b;
  logic [1:0] wr_full_b, wr_en_n_b, rd_en_n_b;
  logic       wr_sel_b, rd_sel_b;
  logic [7:0] drop_b, rep_b;

  fb_ring_ctrl #(.NUM_FB(3), .WR_BURST_SIZE(8), .RD_BURST_SIZE(16), .IDXW(2)) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .init_start(init_start),
    .cam_empty(cam_empty), .cam_rdreq(cam_rdreq), .wr_ready(wr_ready),
    .wr_full(wr_full), .wr_en_n(wr_en_n), .out_full(out_full), .rd_done(rd_done),
    .rd_valid(rd_valid), .rd_en_n(rd_en_n), .out_wrreq(out_wrreq),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .frames_dropped(frames_dropped),
    .frames_repeated(frames_repeated)
  );

  fb_ring_ctrl #(.NUM_FB(2), .WR_BURST_SIZE(4), .RD_BURST_SIZE(4), .IDXW(1)) dut_b (
    .clk(clk), .reset(reset), .init_done(init_done), .init_start(init_start_b),
    .cam_empty(1'b1), .cam_rdreq(cam_rdreq_b), .wr_ready(2'b11),
    .wr_full(wr_full_b), .wr_en_n(wr_en_n_b), .out_full(1'b1), .rd_done(2'b00),
    .rd_valid(2'b00), .rd_en_n(rd_en_n_b), .out_wrreq(out_wrreq_b),
    .wr_sel(wr_sel_b), .rd_sel(rd_sel_b), .frames_dropped(drop_b),
    .frames_repeated(rep_b)
  );

  typedef struct { int wsel; int rsel; int drop; int rep; } stat_t;
  typedef struct { int cyc; int en_n; } beat_t;
  stat_t stat_q[$];
  stat_t stat_qb[$];
  beat_t beat_q[$];
  bit beat_chk = 1'b1;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: selection/counter snapshot after every frame event, beat timing on cam_rdreq.
  initial begin : mon_a
    bit seen;
    stat_t e;
    beat_t b;
    forever begin
      @(posedge clk);
      seen = !reset && ((|wr_full) || (|rd_done));
      @(negedge clk);
      if (seen) begin
        if (stat_q.size() == 0) check("stat_q_underflow", 1, 0);
        else begin
          e = stat_q.pop_front();
          check("wr_sel", int'(wr_sel), e.wsel);
          check("rd_sel", int'(rd_sel), e.rsel);
          check("frames_dropped", int'(frames_dropped), e.drop);
          check("frames_repeated", int'(frames_repeated), e.rep);
        end
      end
      if (beat_chk && cam_rdreq) begin
        if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_cycle", cyc, b.cyc);
          check("beat_wr_en_n", int'(wr_en_n), b.en_n);
        end
      end
    end
  end

  initial begin : mon_b
    bit seen;
    stat_t e;
    forever begin
      @(posedge clk);
      seen = !reset && (|wr_full_b);
      @(negedge clk);
      if (seen) begin
        if (stat_qb.size() == 0) check("stat_qb_underflow", 1, 0);
        else begin
          e = stat_qb.pop_front();
          check("b_wr_sel", int'(wr_sel_b), e.wsel);
          check("b_rd_sel", int'(rd_sel_b), e.rsel);
          check("b_frames_dropped", int'(drop_b), e.drop);
        end
      end
    end
  end

  task automatic pulse_a(input logic [2:0] wf, input logic [2:0] rd,
                         input int ew, input int er, input int ed, input int ep);
    stat_t e;
    e.wsel = ew; e.rsel = er; e.drop = STATS ? ed : 0; e.rep = STATS ? ep : 0;
    stat_q.push_back(e);
    wr_full = wf; rd_done = rd;
    @(posedge clk); #1;
    wr_full = '0; rd_done = '0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_b(input int ed);
    stat_t e;
    e.wsel = 0; e.rsel = 1; e.drop = STATS ? ed : 0; e.rep = 0;
    stat_qb.push_back(e);
    wr_full_b = 2'b01;
    @(posedge clk); #1;
    wr_full_b = '0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    beat_t b;
    cam_empty = 1'b0; wr_ready = '1; out_full = 1'b0;
    wr_full = '0; rd_done = '0; rd_valid = '0; wr_full_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en_n", int'(wr_en_n), 7);
    check("rst_rd_en_n", int'(rd_en_n), 7);
    check("rst_init_start", int'(init_start), 0);
    check("rst_cam_rdreq", int'(cam_rdreq), 0);
    check("rst_out_wrreq", int'(out_wrreq), 0);
    check("rst_wr_sel", int'(wr_sel), 0);
    check("rst_rd_sel", int'(rd_sel), 2);
    check("rst_dropped", int'(frames_dropped), 0);
    check("rst_repeated", int'(frames_repeated), 0);
    check("rst_b_rd_sel", int'(rd_sel_b), 1);

    // Two bursts of 8 beats on buffer 0 (first at cycle 6), one idle cycle between.
    for (int k = 0; k < 16; k++) begin
      b.cyc = (k < 8) ? 6 + k : 7 + k;
      b.en_n = 6;
      beat_q.push_back(b);
    end
    @(posedge clk); #1 reset = 1'b0;

    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (cyc == 5) init_done = 1'b1;
      @(negedge clk);
      check("init_start", int'(init_start), (c == 1) ? 1 : 0);
      check("pre_run_wr_en_n", int'(wr_en_n), 7);
      check("pre_run_rd_en_n", int'(rd_en_n), 7);
      check("pre_run_cam_rdreq", int'(cam_rdreq), 0);
    end
    while (cyc < 10) @(negedge clk);
    check("no_read_before_frame", int'(rd_en_n), 7);
    while (cyc < 23) @(posedge clk);
    #1 cam_empty = 1'b1;
    @(posedge clk); #1;
    check("beats_outstanding", beat_q.size(), 0);

    rd_valid = 3'b010; #1;
    check("out_wrreq_valid", int'(out_wrreq), 1);
    out_full = 1'b1; #1;
    check("out_wrreq_full", int'(out_wrreq), 0);
    rd_valid = 3'b000; out_full = 1'b0; #1;
    check("out_wrreq_idle", int'(out_wrreq), 0);
    @(posedge clk); #1;

    pulse_a(3'b000, 3'b100, 0, 2, 0, 1);   // no frame yet: repeat
    check("no_read_after_repeat", int'(rd_en_n), 7);
    pulse_a(3'b001, 3'b000, 1, 2, 0, 1);
    check("read_after_first_frame", int'(rd_en_n), 3);
    pulse_a(3'b010, 3'b000, 0, 2, 0, 1);   // slot 2 busy, skip to 0
    pulse_a(3'b001, 3'b000, 1, 2, 0, 1);
    pulse_a(3'b000, 3'b100, 1, 0, 0, 1);   // reader takes newest = 0
    pulse_a(3'b000, 3'b001, 1, 0, 0, 2);   // nothing new: repeat
    pulse_a(3'b100, 3'b000, 1, 0, 0, 2);   // non-selected pulse ignored
    pulse_a(3'b010, 3'b001, 2, 0, 0, 3);
    pulse_a(3'b100, 3'b001, 2, 1, 1, 3);   // both candidates blocked: drop
    check("sel_distinct", int'(wr_sel != rd_sel), 1);

    pulse_b(1);
    pulse_b(2);
    for (int k = 3; k <= 260; k++) pulse_b((k > 255) ? 255 : k);

    beat_chk = 1'b0;
    cam_empty = 1'b0;
    #2;
    check("beat_before_reset", int'(wr_en_n), 3);
    #1 reset = 1'b1;
    #1;
    check("reset_wr_en_n", int'(wr_en_n), 7);
    check("reset_rd_en_n", int'(rd_en_n), 7);
    check("reset_cam_rdreq", int'(cam_rdreq), 0);
    repeat (2) @(posedge clk);
    check("stat_q_left", stat_q.size(), 0);
    check("stat_qb_left", stat_qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
